// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// funct3 codes, FSM encodings, the issued-request record and lane helpers.
package mem_access_unit_pkg;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   localparam logic [1:0] MEM_IDLE = 2'b00;
   localparam logic [1:0] MEM_BUSY = 2'b01;
   localparam logic [1:0] MEM_DONE = 2'b10;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [2:0]  funct3;
      logic [1:0]  byte_off;
      logic        is_load;
   } mem_req_t;

   // size encodes funct3[1:0]; 2'b11 is handled as a word access
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic res;
      case (size)
         2'b00:   res = 1'b0;
         2'b01:   res = off[0];
         default: res = (off != 2'b00);
      endcase
      return res;
   endfunction

   function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] res;
      case (size)
         2'b00:   res = 4'b0001 << off;
         2'b01:   res = off[1] ? 4'b1100 : 4'b0011;
         default: res = 4'b1111;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] rs2);
      logic [31:0] res;
      case (size)
         2'b00:   res = {4{rs2[7:0]}};
         2'b01:   res = {2{rs2[15:0]}};
         default: res = rs2;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/halfword of a read word and sign- or
// zero-extends it according to the load funct3.
module mem_access_unit_load_extend
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] raw,
   output logic [31:0] data
);

   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // lane select followed by extension
   always_comb begin
      shifted  = raw >> {byte_off, 3'b000};
      byte_sel = shifted[7:0];
      half_sel = byte_off[1] ? raw[31:16] : raw[15:0];
      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  data = {24'h00_0000, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  data = {16'h0000, half_sel};
         default: data = raw;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: issues one req/ack bus access per
// load/store, stalls the pipeline until completion and returns extended load data.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read_mem,
   input  logic        mem_write_mem,
   input  logic [2:0]  instr_funct3_mem,
   input  logic [31:0] alu_result_mem,
   input  logic [31:0] rs2_data_mem,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] mem_read_data,
   output logic        stall_req,
   output logic        misaligned_exc,
   output logic        bus_error
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       state_r;
   mem_req_t         req_r;
   mem_req_t         req_s;
   logic [CNT_W-1:0] cnt_r;
   logic [31:0]      rdata_r;
   logic             err_r;
   logic             access_s;
   logic             misaligned_s;
   logic             issue_s;
   logic [31:0]      ext_s;

   assign access_s     = mem_read_mem | mem_write_mem;
   assign misaligned_s = is_misaligned(instr_funct3_mem[1:0], alu_result_mem[1:0]);
   assign issue_s      = (state_r == MEM_IDLE) & access_s & ~misaligned_s & ~rst;

   // request record captured on issue; a store wins when both strobes are set
   always_comb begin
      req_s          = '0;
      req_s.addr     = {alu_result_mem[31:2], 2'b00};
      req_s.we       = mem_write_mem;
      req_s.wdata    = mem_write_mem ? store_data(instr_funct3_mem[1:0], rs2_data_mem) : ZERO_WORD;
      req_s.wstrb    = mem_write_mem ? store_strb(instr_funct3_mem[1:0], alu_result_mem[1:0]) : 4'b0000;
      req_s.funct3   = instr_funct3_mem;
      req_s.byte_off = alu_result_mem[1:0];
      req_s.is_load  = mem_read_mem & ~mem_write_mem;
   end

   // access FSM with timeout counter; ack takes priority over timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= MEM_IDLE;
         req_r   <= '0;
         cnt_r   <= '0;
         rdata_r <= ZERO_WORD;
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            MEM_IDLE: begin
               if (issue_s) begin
                  req_r   <= req_s;
                  cnt_r   <= '0;
                  err_r   <= 1'b0;
                  state_r <= MEM_BUSY;
               end
            end
            MEM_BUSY: begin
               if (dmem_ack) begin
                  rdata_r <= dmem_rdata;
                  err_r   <= 1'b0;
                  state_r <= MEM_DONE;
               end else if (cnt_r == CNT_LAST) begin
                  rdata_r <= ZERO_WORD;
                  err_r   <= 1'b1;
                  state_r <= MEM_DONE;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            MEM_DONE: state_r <= MEM_IDLE;
            default:  state_r <= MEM_IDLE;
         endcase
      end
   end

   mem_access_unit_load_extend u_load_extend (
      .funct3   (req_r.funct3),
      .byte_off (req_r.byte_off),
      .raw      (rdata_r),
      .data     (ext_s)
   );

   assign dmem_req       = (state_r == MEM_BUSY);
   assign dmem_we        = req_r.we;
   assign dmem_addr      = req_r.addr;
   assign dmem_wdata     = req_r.wdata;
   assign dmem_wstrb     = req_r.wstrb;
   assign stall_req      = issue_s | (state_r == MEM_BUSY);
   assign misaligned_exc = (state_r == MEM_IDLE) & access_s & misaligned_s;
   assign bus_error      = (state_r == MEM_DONE) & err_r;
   assign mem_read_data  = ((state_r == MEM_DONE) && req_r.is_load) ? ext_s : ZERO_WORD;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        mem_read_mem;
   logic        mem_write_mem;
   logic [2:0]  instr_funct3_mem;
   logic [31:0] alu_result_mem;
   logic [31:0] rs2_data_mem;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [31:0] mem_read_data;
   logic        stall_req;
   logic        misaligned_exc;
   logic        bus_error;

   int errors = 0;
   int checks = 0;

   // results of the most recent run_access
   logic        r_done;
   int          r_busy;
   int          r_stall;
   logic [31:0] r_data;
   logic        r_err;
   logic [31:0] r_addr;
   logic [3:0]  r_wstrb;
   logic [31:0] r_wdata;
   logic        r_we;

   mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .clk              (clk),
      .rst              (rst),
      .mem_read_mem     (mem_read_mem),
      .mem_write_mem    (mem_write_mem),
      .instr_funct3_mem (instr_funct3_mem),
      .alu_result_mem   (alu_result_mem),
      .rs2_data_mem     (rs2_data_mem),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_wdata       (dmem_wdata),
      .dmem_wstrb       (dmem_wstrb),
      .dmem_ack         (dmem_ack),
      .dmem_rdata       (dmem_rdata),
      .mem_read_data    (mem_read_data),
      .stall_req        (stall_req),
      .misaligned_exc   (misaligned_exc),
      .bus_error        (bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one access; ack_at = BUSY cycle (1-based) carrying the ack, 0 = never.
   // Returns at the DONE cycle (or after a bounded number of cycles).
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] rs2,
                             input logic [31:0] rdata, input int ack_at);
      r_done = 1'b0; r_busy = 0; r_stall = 0; r_data = 32'h0; r_err = 1'b0;
      r_addr = 32'h0; r_wstrb = 4'h0; r_wdata = 32'h0; r_we = 1'b0;
      @(negedge clk);
      mem_read_mem = rd; mem_write_mem = wr; instr_funct3_mem = f3;
      alu_result_mem = addr; rs2_data_mem = rs2; dmem_rdata = rdata;
      for (int c = 0; c < 40 && !r_done; c++) begin
         if (c > 0) @(negedge clk);
         dmem_ack = dmem_req && (ack_at != 0) && (r_busy + 1 == ack_at);
         #1;
         if (dmem_req && r_busy == 0) begin
            r_addr = dmem_addr; r_wstrb = dmem_wstrb; r_wdata = dmem_wdata; r_we = dmem_we;
         end
         if (stall_req) r_stall++;
         if (dmem_req) r_busy++;
         if (!stall_req && r_busy > 0) begin
            r_done = 1'b1; r_data = mem_read_data; r_err = bus_error;
         end
      end
      dmem_ack = 1'b0; mem_read_mem = 1'b0; mem_write_mem = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; mem_read_mem = 1'b0; mem_write_mem = 1'b0; instr_funct3_mem = 3'b000;
      alu_result_mem = 32'h0; rs2_data_mem = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
      @(negedge clk); @(negedge clk); #1;
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
      checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", dmem_we); end
      checks++; if (dmem_wstrb !== 4'b0000) begin errors++; $display("FAIL reset_wstrb got=%b exp=0000", dmem_wstrb); end
      checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", mem_read_data); end
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
      checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_buserr got=%b exp=0", bus_error); end
      rst = 1'b0;
   endtask

   task automatic test_store_lanes;
      run_access(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 2);
      checks++; if (r_done !== 1'b1) begin errors++; $display("FAIL sb_done got=%b exp=1", r_done); end
      checks++; if (r_stall != 3) begin errors++; $display("FAIL sb_stall_cycles got=%0d exp=3", r_stall); end
      checks++; if (r_busy != 2) begin errors++; $display("FAIL sb_busy_cycles got=%0d exp=2", r_busy); end
      checks++; if (r_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr got=%h exp=00001000", r_addr); end
      checks++; if (r_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb got=%b exp=1000", r_wstrb); end
      checks++; if (r_wdata !== 32'hDDDD_DDDD) begin errors++; $display("FAIL sb_wdata got=%h exp=dddddddd", r_wdata); end
      checks++; if (r_we !== 1'b1) begin errors++; $display("FAIL sb_we got=%b exp=1", r_we); end
      checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL sb_read_data got=%h exp=0", r_data); end
      run_access(1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 32'h0, 1);
      checks++; if (r_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb got=%b exp=1100", r_wstrb); end
      checks++; if (r_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got=%h exp=beefbeef", r_wdata); end
      checks++; if (r_stall != 2) begin errors++; $display("FAIL sh_stall_cycles got=%0d exp=2", r_stall); end
      // load and store both set: store wins
      run_access(1'b1, 1'b1, 3'b000, 32'h0000_1001, 32'h0000_0077, 32'hFFFF_FFFF, 1);
      checks++; if (r_wstrb !== 4'b0010 || r_we !== 1'b1) begin errors++; $display("FAIL rdwr_store got=%b/%b exp=0010/1", r_wstrb, r_we); end
      checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL rdwr_data got=%h exp=0", r_data); end
   endtask

   task automatic test_load_extend;
      run_access(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_8000, 1);
      checks++; if (r_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb got=%h exp=ffffff80", r_data); end
      checks++; if (r_wstrb !== 4'b0000 || r_we !== 1'b0) begin errors++; $display("FAIL lb_strb got=%b/%b exp=0000/0", r_wstrb, r_we); end
      run_access(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_8000, 1);
      checks++; if (r_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu got=%h exp=00000080", r_data); end
      run_access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 3);
      checks++; if (r_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh got=%h exp=ffff8001", r_data); end
      checks++; if (r_busy != 3) begin errors++; $display("FAIL lh_busy got=%0d exp=3", r_busy); end
      run_access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, 1);
      checks++; if (r_data !== 32'h0000_8001) begin errors++; $display("FAIL lhu got=%h exp=00008001", r_data); end
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hCAFE_F00D, 1);
      checks++; if (r_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL lw got=%h exp=cafef00d", r_data); end
      @(negedge clk); #1;
      checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL rdata_idle got=%h exp=0", mem_read_data); end
   endtask

   task automatic test_misaligned;
      logic seen_req;
      logic seen_stall;
      seen_req = 1'b0; seen_stall = 1'b0;
      @(negedge clk);
      mem_read_mem = 1'b1; instr_funct3_mem = 3'b010; alu_result_mem = 32'h0000_2002;
      #1;
      checks++; if (misaligned_exc !== 1'b1) begin errors++; $display("FAIL lw_mis_exc got=%b exp=1", misaligned_exc); end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         if (dmem_req) seen_req = 1'b1;
         if (stall_req) seen_stall = 1'b1;
      end
      checks++; if (seen_req !== 1'b0) begin errors++; $display("FAIL lw_mis_req got=%b exp=0", seen_req); end
      checks++; if (seen_stall !== 1'b0) begin errors++; $display("FAIL lw_mis_stall got=%b exp=0", seen_stall); end
      mem_read_mem = 1'b0; mem_write_mem = 1'b1; instr_funct3_mem = 3'b001; alu_result_mem = 32'h0000_1001;
      #1;
      checks++; if (misaligned_exc !== 1'b1 || stall_req !== 1'b0) begin errors++; $display("FAIL sh_mis got=%b/%b exp=1/0", misaligned_exc, stall_req); end
      instr_funct3_mem = 3'b000;
      #1;
      checks++; if (misaligned_exc !== 1'b0) begin errors++; $display("FAIL sb_aligned got=%b exp=0", misaligned_exc); end
      mem_write_mem = 1'b0;
      #1;
      checks++; if (misaligned_exc !== 1'b0) begin errors++; $display("FAIL mis_noaccess got=%b exp=0", misaligned_exc); end
   endtask

   task automatic test_timeout;
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h5555_5555, 0);
      checks++; if (r_done !== 1'b1) begin errors++; $display("FAIL to_done got=%b exp=1", r_done); end
      checks++; if (r_busy != 16) begin errors++; $display("FAIL to_busy got=%0d exp=16", r_busy); end
      checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL to_buserr got=%b exp=1", r_err); end
      checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL to_data got=%h exp=0", r_data); end
      @(negedge clk); #1;
      checks++; if (bus_error !== 1'b0 || stall_req !== 1'b0) begin errors++; $display("FAIL to_after got=%b/%b exp=0/0", bus_error, stall_req); end
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'h0, 32'h1234_5678, 16);
      checks++; if (r_busy != 16) begin errors++; $display("FAIL ack16_busy got=%0d exp=16", r_busy); end
      checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL ack16_buserr got=%b exp=0", r_err); end
      checks++; if (r_data !== 32'h1234_5678) begin errors++; $display("FAIL ack16_data got=%h exp=12345678", r_data); end
   endtask

   task automatic test_stray_ack;
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = 32'h9999_9999;
      #1;
      checks++; if (dmem_req !== 1'b0 || stall_req !== 1'b0) begin errors++; $display("FAIL stray_idle got=%b/%b exp=0/0", dmem_req, stall_req); end
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      checks++; if (dmem_req !== 1'b0 || mem_read_data !== 32'h0) begin errors++; $display("FAIL stray_after got=%b/%h exp=0/0", dmem_req, mem_read_data); end
   endtask

   task automatic test_reset_mid_busy;
      @(negedge clk);
      mem_read_mem = 1'b1; instr_funct3_mem = 3'b010; alu_result_mem = 32'h0000_5000;
      @(negedge clk); #1;
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rb_busy got=%b exp=1", dmem_req); end
      #2;
      rst = 1'b1; mem_read_mem = 1'b0;
      #1;
      checks++; if (dmem_req !== 1'b0 || stall_req !== 1'b0) begin errors++; $display("FAIL rb_drop got=%b/%b exp=0/0", dmem_req, stall_req); end
      @(negedge clk);
      rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      checks++; if (dmem_req !== 1'b0 || stall_req !== 1'b0 || mem_read_data !== 32'h0) begin
         errors++; $display("FAIL rb_late_ack got=%b/%b/%h exp=0/0/0", dmem_req, stall_req, mem_read_data);
      end
      run_access(1'b0, 1'b1, 3'b010, 32'h0000_4004, 32'h1122_3344, 32'h0, 1);
      checks++; if (r_done !== 1'b1 || r_stall != 2) begin errors++; $display("FAIL rb_sw_done got=%b/%0d exp=1/2", r_done, r_stall); end
      checks++; if (r_addr !== 32'h0000_4004 || r_wstrb !== 4'b1111) begin errors++; $display("FAIL rb_sw_bus got=%h/%b exp=00004004/1111", r_addr, r_wstrb); end
      checks++; if (r_wdata !== 32'h1122_3344) begin errors++; $display("FAIL rb_sw_wdata got=%h exp=11223344", r_wdata); end
   endtask

   initial begin
      test_reset;
      test_store_lanes;
      test_load_extend;
      test_misaligned;
      test_timeout;
      test_stray_ack;
      test_reset_mid_busy;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
